// File: rtl/ipv4_pkg.sv
// Shared IPv4 TX/RX definitions: header layout, FSM states and the
// ones-complement fold used by the header checksum.
package ipv4_pkg;

  localparam int          IPV4_HDR_BYTES  = 20;
  localparam logic [7:0]  IPV4_VER_IHL    = 8'h45;
  localparam logic [15:0] MAX_PAYLOAD_LEN = 16'd65515;

  localparam int OFF_VER_IHL   = 0;
  localparam int OFF_TOS       = 1;
  localparam int OFF_TOTAL_LEN = 2;
  localparam int OFF_IDENT     = 4;
  localparam int OFF_FLAGS     = 6;
  localparam int OFF_TTL       = 8;
  localparam int OFF_PROTO     = 9;
  localparam int OFF_CSUM      = 10;
  localparam int OFF_SRC       = 12;
  localparam int OFF_DST       = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSUM,
    ST_HDR0,
    ST_HDR1,
    ST_MERGE,
    ST_PAYLOAD,
    ST_FLUSH
  } ipv4_tx_state_t;

  // Two folds always suffice for a sum of ten 16-bit words in 20 bits.
  function automatic logic [15:0] ipv4_fold2(input logic [19:0] s);
    logic [19:0] f;
    f = {4'h0, s[15:0]} + {16'h0000, s[19:16]};
    f = {4'h0, f[15:0]} + {16'h0000, f[19:16]};
    return f[15:0];
  endfunction

endpackage

// File: rtl/ipv4_csum.sv
// IPv4 header checksum over ten 16-bit words (checksum word supplied as 0),
// registered when en is high. Usable by an RX checker as well.
module ipv4_csum
  import ipv4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [9:0][15:0] words,
  output logic [15:0]      csum
);

  logic [19:0] sum;
  logic [15:0] csum_d, csum_q;

  always_comb begin
    sum = 20'h00000;
    for (int i = 0; i < 10; i++) begin
      sum = sum + {4'h0, words[i]};
    end
    csum_d = en ? ~ipv4_fold2(sum) : csum_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= 16'h0000;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;

endmodule

// File: rtl/ipv4_header_builder.sv
// TX IPv4 encapsulator: emits a 20-byte header then the L4 payload shifted
// by 4 byte lanes, with checksum, identification and length checking.
module ipv4_header_builder
  import ipv4_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter logic [7:0]  TTL        = 8'h40,
  parameter logic [7:0]  TOS        = 8'h00,
  parameter logic [15:0] FLAGS_FRAG = 16'h4000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hdr_valid,
  output logic                  hdr_ready,
  input  logic [31:0]           src_ip,
  input  logic [31:0]           dst_ip,
  input  logic [7:0]            protocol,
  input  logic [15:0]           payload_len,
  input  logic [DATA_WIDTH-1:0] tdata_in,
  input  logic [3:0]            idx_in,
  input  logic                  data_valid_in,
  input  logic                  last_flag_in,
  output logic                  builder_ready,
  output logic [DATA_WIDTH-1:0] tdata_out,
  output logic [3:0]            idx_out,
  output logic                  data_valid_out,
  output logic                  last_flag_out,
  input  logic                  downstream_ready,
  output logic                  len_err
);

  ipv4_tx_state_t        state_d, state_q;
  logic [15:0]           ident_d, ident_q;
  logic [15:0]           pkt_ident_d, pkt_ident_q;
  logic [31:0]           src_d, src_q, dst_d, dst_q;
  logic [7:0]            proto_d, proto_q;
  logic [15:0]           len_d, len_q;
  logic [16:0]           rx_cnt_d, rx_cnt_q;
  logic [31:0]           residual_d, residual_q;
  logic [3:0]            res_cnt_d, res_cnt_q;
  logic [DATA_WIDTH-1:0] tdata_d, tdata_q;
  logic [3:0]            idx_d, idx_q;
  logic                  dv_d, dv_q, last_d, last_q, len_err_d, len_err_q;

  logic [15:0]      total_len, csum;
  logic [9:0][15:0] csum_words;
  logic [7:0]       hdr_b [IPV4_HDR_BYTES];
  logic [63:0]      hdr_beat0, hdr_beat1;
  logic [31:0]      hdr_tail;
  logic             can_load, in_payload, beat_acc;
  logic [16:0]      rx_sum;

  assign total_len  = len_q + 16'(IPV4_HDR_BYTES);
  assign csum_words = {dst_q[15:0], dst_q[31:16], src_q[15:0], src_q[31:16], 16'h0000,
                       TTL, proto_q, FLAGS_FRAG, pkt_ident_q, total_len, IPV4_VER_IHL, TOS};

  ipv4_csum u_csum (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == ST_CSUM),
    .words (csum_words),
    .csum  (csum)
  );

  always_comb begin
    for (int i = 0; i < IPV4_HDR_BYTES; i++) begin
      hdr_b[i] = 8'h00;
    end
    hdr_b[OFF_VER_IHL]     = IPV4_VER_IHL;
    hdr_b[OFF_TOS]         = TOS;
    hdr_b[OFF_TOTAL_LEN]   = total_len[15:8];
    hdr_b[OFF_TOTAL_LEN+1] = total_len[7:0];
    hdr_b[OFF_IDENT]       = pkt_ident_q[15:8];
    hdr_b[OFF_IDENT+1]     = pkt_ident_q[7:0];
    hdr_b[OFF_FLAGS]       = FLAGS_FRAG[15:8];
    hdr_b[OFF_FLAGS+1]     = FLAGS_FRAG[7:0];
    hdr_b[OFF_TTL]         = TTL;
    hdr_b[OFF_PROTO]       = proto_q;
    hdr_b[OFF_CSUM]        = csum[15:8];
    hdr_b[OFF_CSUM+1]      = csum[7:0];
    for (int i = 0; i < 4; i++) begin
      hdr_b[OFF_SRC+i] = src_q[31-8*i -: 8];
      hdr_b[OFF_DST+i] = dst_q[31-8*i -: 8];
    end
    hdr_beat0 = 64'h0;
    hdr_beat1 = 64'h0;
    hdr_tail  = 32'h0;
    for (int i = 0; i < 8; i++) begin
      hdr_beat0[8*i +: 8] = hdr_b[i];
      hdr_beat1[8*i +: 8] = hdr_b[8+i];
    end
    for (int i = 0; i < 4; i++) begin
      hdr_tail[8*i +: 8] = hdr_b[OFF_DST+i];
    end
  end

  assign can_load      = !dv_q || downstream_ready;
  assign in_payload    = (state_q == ST_MERGE || state_q == ST_PAYLOAD) && (len_q != 16'd0);
  assign builder_ready = in_payload && can_load;
  assign beat_acc      = data_valid_in && builder_ready;
  assign rx_sum        = rx_cnt_q + {13'd0, idx_in};

  // Header bytes 16-19 sit in the residual after HDR1, so MERGE and PAYLOAD
  // share the same {in[0..3], residual} realignment path.
  always_comb begin
    state_d     = state_q;
    ident_d     = ident_q;
    pkt_ident_d = pkt_ident_q;
    src_d       = src_q;
    dst_d       = dst_q;
    proto_d     = proto_q;
    len_d       = len_q;
    rx_cnt_d    = rx_cnt_q;
    residual_d  = residual_q;
    res_cnt_d   = res_cnt_q;
    tdata_d     = tdata_q;
    idx_d       = idx_q;
    last_d      = last_q;
    dv_d        = dv_q && !downstream_ready;
    len_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hdr_valid) begin
          src_d       = src_ip;
          dst_d       = dst_ip;
          proto_d     = protocol;
          len_d       = payload_len;
          pkt_ident_d = ident_q;
          rx_cnt_d    = 17'd0;
          state_d     = ST_CSUM;
        end
      end
      ST_CSUM: begin
        ident_d = ident_q + 16'd1;
        if (len_q > MAX_PAYLOAD_LEN) begin
          len_err_d = 1'b1;
        end
        state_d = ST_HDR0;
      end
      ST_HDR0: begin
        if (can_load) begin
          tdata_d = hdr_beat0;
          idx_d   = 4'd8;
          last_d  = 1'b0;
          dv_d    = 1'b1;
          state_d = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (can_load) begin
          tdata_d    = hdr_beat1;
          idx_d      = 4'd8;
          last_d     = 1'b0;
          dv_d       = 1'b1;
          residual_d = hdr_tail;
          res_cnt_d  = 4'd4;
          state_d    = ST_MERGE;
        end
      end
      ST_MERGE, ST_PAYLOAD: begin
        if (len_q == 16'd0) begin
          if (can_load) begin
            tdata_d = {32'h0, residual_q};
            idx_d   = 4'd4;
            last_d  = 1'b1;
            dv_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (beat_acc) begin
          rx_cnt_d   = rx_sum;
          tdata_d    = {tdata_in[31:0], residual_q};
          residual_d = tdata_in[63:32];
          dv_d       = 1'b1;
          idx_d      = 4'd8;
          last_d     = 1'b0;
          state_d    = ST_PAYLOAD;
          if (last_flag_in) begin
            if (rx_sum != {1'b0, len_q}) begin
              len_err_d = 1'b1;
            end
            if (idx_in <= 4'd4) begin
              idx_d   = idx_in + 4'd4;
              last_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              res_cnt_d = idx_in - 4'd4;
              state_d   = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (can_load) begin
          tdata_d = {32'h0, residual_q};
          idx_d   = res_cnt_q;
          last_d  = 1'b1;
          dv_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ident_q     <= 16'h0000;
      pkt_ident_q <= 16'h0000;
      src_q       <= 32'h0;
      dst_q       <= 32'h0;
      proto_q     <= 8'h00;
      len_q       <= 16'h0000;
      rx_cnt_q    <= 17'd0;
      residual_q  <= 32'h0;
      res_cnt_q   <= 4'd0;
      tdata_q     <= '0;
      idx_q       <= 4'd0;
      dv_q        <= 1'b0;
      last_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ident_q     <= ident_d;
      pkt_ident_q <= pkt_ident_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      proto_q     <= proto_d;
      len_q       <= len_d;
      rx_cnt_q    <= rx_cnt_d;
      residual_q  <= residual_d;
      res_cnt_q   <= res_cnt_d;
      tdata_q     <= tdata_d;
      idx_q       <= idx_d;
      dv_q        <= dv_d;
      last_q      <= last_d;
      len_err_q   <= len_err_d;
    end
  end

  assign hdr_ready      = (state_q == ST_IDLE);
  assign tdata_out      = tdata_q;
  assign idx_out        = idx_q;
  assign data_valid_out = dv_q;
  assign last_flag_out  = last_q;
  assign len_err        = len_err_q;

endmodule

// File: tb/tb_ipv4_header_builder.sv
// Directed bench for ipv4_header_builder: a table of packets with hand-computed
// ident/checksum, a byte-level reference stream, plus stall and reset sequences.
module tb_ipv4_header_builder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hdr_valid = 1'b0;
  logic        hdr_ready;
  logic [31:0] src_ip = 32'h0;
  logic [31:0] dst_ip = 32'h0;
  logic [7:0]  protocol = 8'h00;
  logic [15:0] payload_len = 16'h0;
  logic [63:0] tdata_in = 64'h0;
  logic [3:0]  idx_in = 4'd0;
  logic        data_valid_in = 1'b0;
  logic        last_flag_in = 1'b0;
  logic        builder_ready;
  logic [63:0] tdata_out;
  logic [3:0]  idx_out;
  logic        data_valid_out;
  logic        last_flag_out;
  logic        downstream_ready = 1'b1;
  logic        len_err;

  ipv4_header_builder dut (
    .clk              (clk),
    .rst              (rst),
    .hdr_valid        (hdr_valid),
    .hdr_ready        (hdr_ready),
    .src_ip           (src_ip),
    .dst_ip           (dst_ip),
    .protocol         (protocol),
    .payload_len      (payload_len),
    .tdata_in         (tdata_in),
    .idx_in           (idx_in),
    .data_valid_in    (data_valid_in),
    .last_flag_in     (last_flag_in),
    .builder_ready    (builder_ready),
    .tdata_out        (tdata_out),
    .idx_out          (idx_out),
    .data_valid_out   (data_valid_out),
    .last_flag_out    (last_flag_out),
    .downstream_ready (downstream_ready),
    .len_err          (len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [7:0]  proto;
    logic [15:0] len;
    int          nsent;
    bit          stall;
    logic [15:0] exp_ident;
    logic [15:0] exp_csum;
    int          exp_errs;
  } vec_t;

  vec_t vecs [8];

  logic [7:0] hdr_t1 [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                              8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};

  int n_checks = 0;
  int n_pass   = 0;

  bit          stall_en = 1'b0;
  logic [7:0]  got_bytes [$];
  logic [7:0]  exp_bytes [$];
  int          beat_idx [$];
  int          n_last, n_err, n_bready, n_stalls, hold_viol;
  bit          seen_dv, hold_pending;
  longint      t_first;
  logic [63:0] hold_data;
  logic [3:0]  hold_idx;
  logic        hold_last;

  // Downstream backpressure, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    downstream_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (data_valid_out && !seen_dv) begin
      seen_dv = 1'b1;
      t_first = $time;
    end
    if (len_err) n_err++;
    if (builder_ready) n_bready++;
    if (hold_pending) begin
      if (!(data_valid_out && tdata_out == hold_data && idx_out == hold_idx &&
            last_flag_out == hold_last)) hold_viol++;
      hold_pending = 1'b0;
    end
    if (data_valid_out && !downstream_ready) begin
      hold_pending = 1'b1;
      hold_data    = tdata_out;
      hold_idx     = idx_out;
      hold_last    = last_flag_out;
      n_stalls++;
    end
    if (data_valid_out && downstream_ready) begin
      for (int j = 0; j < int'(idx_out); j++) got_bytes.push_back(tdata_out[8*j +: 8]);
      beat_idx.push_back(int'(idx_out));
      if (last_flag_out) n_last++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic sendHeader(input vec_t v, output longint t0);
    bit acc;
    src_ip      = v.src;
    dst_ip      = v.dst;
    protocol    = v.proto;
    payload_len = v.len;
    hdr_valid   = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      acc = hdr_ready;
      @(posedge clk);
    end
    t0 = $time;
    #1;
    hdr_valid = 1'b0;
    if (!acc) checkOutput("header accept timeout", 64'd0, 64'd1);
  endtask

  task automatic sendBeat(input int b, input int nsent, input bit last);
    bit acc;
    for (int j = 0; j < 8; j++)
      tdata_in[8*j +: 8] = (8*b + j < nsent) ? 8'(8*b + j + 1) : 8'h00;
    idx_in        = (nsent - 8*b >= 8) ? 4'd8 : 4'(nsent - 8*b);
    last_flag_in  = last;
    data_valid_in = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 300 && !acc; c++) begin
      @(negedge clk);
      acc = builder_ready;
      @(posedge clk);
    end
    #1;
    data_valid_in = 1'b0;
    last_flag_in  = 1'b0;
    if (!acc) checkOutput("payload accept timeout", 64'd0, 64'd1);
  endtask

  task automatic clearMonitor();
    got_bytes.delete();
    beat_idx.delete();
    n_last = 0; n_err = 0; n_bready = 0; n_stalls = 0; hold_viol = 0;
    seen_dv = 1'b0; hold_pending = 1'b0;
  endtask

  task automatic applyStimulus(input int id, input vec_t v);
    longint      t0;
    int          nbeats, mism, short_beats, exp_len;
    logic [15:0] tot;
    clearMonitor();
    stall_en = v.stall;
    sendHeader(v, t0);
    nbeats = (v.nsent + 7) / 8;
    for (int b = 0; b < nbeats; b++) sendBeat(b, v.nsent, b == nbeats - 1);
    for (int c = 0; c < 400 && n_last == 0; c++) @(negedge clk);
    if (n_last == 0) checkOutput($sformatf("pkt%0d last beat timeout", id), 64'd0, 64'd1);
    stall_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    tot = v.len + 16'd20;
    exp_bytes.delete();
    exp_bytes.push_back(8'h45); exp_bytes.push_back(8'h00);
    exp_bytes.push_back(tot[15:8]); exp_bytes.push_back(tot[7:0]);
    exp_bytes.push_back(v.exp_ident[15:8]); exp_bytes.push_back(v.exp_ident[7:0]);
    exp_bytes.push_back(8'h40); exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h40); exp_bytes.push_back(v.proto);
    exp_bytes.push_back(v.exp_csum[15:8]); exp_bytes.push_back(v.exp_csum[7:0]);
    for (int i = 3; i >= 0; i--) exp_bytes.push_back(v.src[8*i +: 8]);
    for (int i = 3; i >= 0; i--) exp_bytes.push_back(v.dst[8*i +: 8]);
    for (int i = 0; i < v.nsent; i++) exp_bytes.push_back(8'(i + 1));
    exp_len = exp_bytes.size();

    checkOutput($sformatf("pkt%0d byte count", id), 64'(got_bytes.size()), 64'(exp_len));
    mism = 0;
    for (int i = 0; i < exp_len && i < got_bytes.size(); i++)
      if (got_bytes[i] !== exp_bytes[i]) mism++;
    checkOutput($sformatf("pkt%0d stream mismatches", id), 64'(mism), 64'd0);
    if (got_bytes.size() >= 20) begin
      checkOutput($sformatf("pkt%0d ident", id), {48'h0, got_bytes[4], got_bytes[5]}, {48'h0, v.exp_ident});
      checkOutput($sformatf("pkt%0d checksum", id), {48'h0, got_bytes[10], got_bytes[11]}, {48'h0, v.exp_csum});
    end else begin
      checkOutput($sformatf("pkt%0d header present", id), 64'(got_bytes.size()), 64'd20);
    end
    checkOutput($sformatf("pkt%0d beat count", id), 64'(beat_idx.size()), 64'((exp_len + 7) / 8));
    short_beats = 0;
    for (int k = 0; k + 1 < beat_idx.size(); k++) if (beat_idx[k] != 8) short_beats++;
    checkOutput($sformatf("pkt%0d short inner beats", id), 64'(short_beats), 64'd0);
    checkOutput($sformatf("pkt%0d last idx", id),
                64'(beat_idx.size() > 0 ? beat_idx[beat_idx.size()-1] : 0), 64'(((exp_len - 1) % 8) + 1));
    checkOutput($sformatf("pkt%0d last flags", id), 64'(n_last), 64'd1);
    checkOutput($sformatf("pkt%0d len_err pulses", id), 64'(n_err), 64'(v.exp_errs));
    if (v.len == 16'd0)
      checkOutput($sformatf("pkt%0d builder_ready cycles", id), 64'(n_bready), 64'd0);
    if (v.stall) begin
      checkOutput($sformatf("pkt%0d hold violations", id), 64'(hold_viol), 64'd0);
      checkOutput($sformatf("pkt%0d stalls seen", id), 64'(n_stalls > 0), 64'd1);
    end else begin
      checkOutput($sformatf("pkt%0d header latency", id), 64'(t_first - t0), 64'd25);
    end
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, " flags"},
                {56'h0, data_valid_out, last_flag_out, len_err, builder_ready, hdr_ready, idx_out[2:0]},
                {56'h0, 8'b0000_1000});
    checkOutput({name, " idx"}, {60'h0, idx_out}, 64'h0);
    checkOutput({name, " tdata"}, tdata_out, 64'h0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int   mism;
    longint t0;

    vecs[0] = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd95,    95, 1'b0, 16'd0, 16'hB861, 0};
    vecs[1] = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd8,      8, 1'b0, 16'd1, 16'hB8B7, 0};
    vecs[2] = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd3,      3, 1'b0, 16'd2, 16'hB8BB, 0};
    vecs[3] = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd0,      0, 1'b0, 16'd3, 16'hB8BD, 0};
    vecs[4] = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd64,    64, 1'b1, 16'd4, 16'hB87C, 0};
    vecs[5] = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd20,    16, 1'b0, 16'd5, 16'hB8A7, 1};
    vecs[6] = '{32'h0A000001, 32'h0A000002, 8'h06, 16'd12,    12, 1'b0, 16'd6, 16'h26D0, 0};
    vecs[7] = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd65520,  8, 1'b0, 16'd7, 16'hB8C9, 2};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(0, vecs[0]);
    mism = 0;
    for (int i = 0; i < 20 && i < got_bytes.size(); i++) if (got_bytes[i] !== hdr_t1[i]) mism++;
    checkOutput("pkt0 reference header bytes", 64'(mism), 64'd0);

    for (int i = 1; i < 8; i++) applyStimulus(i, vecs[i]);

    // Abandon a packet mid-payload with reset; no final beat may appear.
    clearMonitor();
    v = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd64, 64, 1'b0, 16'd8, 16'h0000, 0};
    sendHeader(v, t0);
    sendBeat(0, 64, 1'b0);
    sendBeat(1, 64, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkIdleOutputs("mid-packet reset");
    repeat (5) @(posedge clk);
    #1;
    checkOutput("abandoned packet last flags", 64'(n_last), 64'd0);

    v = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd8, 8, 1'b0, 16'd0, 16'hB8B8, 0};
    applyStimulus(8, v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
